mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch vs. data) in front of a single memory port.
// Data wins ties unless fetch has been passed over STARVE_MAX times in a row; stuck requests time out.
module mem_port_arbiter #(
  parameter logic [7:0] TIMEOUT    = 8'd255,
  parameter logic [2:0] STARVE_MAX = 3'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  // data requester
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  // shared memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  // status
  output logic        if_stall,
  output logic        dm_stall,
  output logic        bus_err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned SW = 3;
  localparam int unsigned TW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2
  } state_t;

  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic [TW-1:0]   wait_cnt;

  logic in_grant_c;
  logic ack_c;
  logic timeout_c;
  logic done_c;
  logic starved_c;

  // Completion decode: an ack always beats a same-cycle timeout.
  assign in_grant_c = (state == GNT_IF) || (state == GNT_DM);
  assign ack_c      = in_grant_c && mem_ack;
  assign timeout_c  = in_grant_c && !mem_ack && (wait_cnt == TIMEOUT);
  assign done_c     = ack_c || timeout_c;
  assign starved_c  = if_req && (starve_cnt == STARVE_MAX);

  assign if_ready = (state == GNT_IF) && done_c;
  assign dm_ready = (state == GNT_DM) && done_c;
  assign if_rdata = ((state == GNT_IF) && ack_c) ? mem_rdata : DW'(0);
  assign dm_rdata = ((state == GNT_DM) && ack_c) ? mem_rdata : DW'(0);

  assign if_stall = if_req && !if_ready;
  assign dm_stall = dm_req && !dm_ready;

  // Grant FSM with latched request bundle; requester inputs only matter in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= SW'(0);
      wait_cnt   <= TW'(0);
      bus_err    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= BW'(0);
      mem_addr   <= AW'(0);
      mem_wdata  <= DW'(0);
    end else begin
      case (state)
        IDLE: begin
          if (dm_req && !starved_c) begin
            state     <= GNT_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_be    <= dm_be;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            wait_cnt  <= TW'(0);
            if (if_req && (starve_cnt < STARVE_MAX)) begin
              starve_cnt <= starve_cnt + SW'(1);
            end
          end else if (if_req) begin
            state      <= GNT_IF;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_be     <= 4'hF;
            mem_addr   <= if_addr;
            mem_wdata  <= DW'(0);
            wait_cnt   <= TW'(0);
            starve_cnt <= SW'(0);
          end
        end
        GNT_IF, GNT_DM: begin
          if (done_c) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= BW'(0);
            if (timeout_c) begin
              bus_err <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        if_stall;
  logic        dm_stall;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  int if_pulses = 0;
  int dm_pulses = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .if_stall(if_stall), .dm_stall(dm_stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Ready pulses counted from the value held just before each rising edge.
  always @(posedge clk) begin
    if (if_ready) if_pulses++;
    if (dm_ready) dm_pulses++;
  end

  initial begin
    #200us;
    $display("FAIL watchdog sim time exceeded, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_be = '0; dm_addr = '0; dm_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b exp 0", mem_req); end
    checks++; if ({mem_we, mem_be} !== 5'd0) begin errors++; $display("FAIL reset_we_be got %0b/%h exp 0/0", mem_we, mem_be); end
    checks++; if ({mem_addr, mem_wdata} !== 64'd0) begin errors++; $display("FAIL reset_bundle got %h/%h exp 0/0", mem_addr, mem_wdata); end
    checks++; if ({bus_err, if_ready, dm_ready} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {bus_err, if_ready, dm_ready}); end
    rst_n = 1'b1;
  endtask

  task automatic test_ack_idle();
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    #1;
    checks++; if ({if_ready, dm_ready} !== 2'b00) begin errors++; $display("FAIL idle_ack_ready got %b exp 00", {if_ready, dm_ready}); end
    checks++; if ({if_rdata, dm_rdata} !== 64'd0) begin errors++; $display("FAIL idle_ack_rdata got %h/%h exp 0/0", if_rdata, dm_rdata); end
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_ack_mem_req got %0b exp 0", mem_req); end
  endtask

  task automatic test_fetch();
    int p0;
    p0 = if_pulses;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_3000;
    @(negedge clk);
    checks++; if ({mem_req, mem_we, mem_be} !== 6'b10_1111) begin errors++; $display("FAIL fetch_ctl got req=%0b we=%0b be=%h exp 1/0/f", mem_req, mem_we, mem_be); end
    checks++; if (mem_addr !== 32'h0000_3000) begin errors++; $display("FAIL fetch_addr got %h exp 00003000", mem_addr); end
    checks++; if ({if_stall, if_ready} !== 2'b10) begin errors++; $display("FAIL fetch_pre_ack got stall/ready %b exp 10", {if_stall, if_ready}); end
    mem_ack = 1'b1; mem_rdata = 32'h3C01_1234;
    #1;
    checks++; if ({if_ready, if_stall, dm_ready} !== 3'b100) begin errors++; $display("FAIL fetch_ack got ready/stall/dm %b exp 100", {if_ready, if_stall, dm_ready}); end
    checks++; if (if_rdata !== 32'h3C01_1234) begin errors++; $display("FAIL fetch_rdata got %h exp 3c011234", if_rdata); end
    @(negedge clk);
    mem_ack = 1'b0; if_req = 1'b0;
    checks++; if ({mem_req, if_ready, if_rdata} !== 34'd0) begin errors++; $display("FAIL fetch_idle got req=%0b ready=%0b rdata=%h exp 0/0/0", mem_req, if_ready, if_rdata); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || if_pulses !== p0 + 1) begin errors++; $display("FAIL fetch_no_regrant got req=%0b pulses=%0d exp 0/%0d", mem_req, if_pulses - p0, 1); end
  endtask

  task automatic test_simultaneous();
    int pi, pd;
    pi = if_pulses; pd = dm_pulses;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0400;
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h0000_0010; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if ({mem_req, mem_we, mem_be} !== 6'b11_1111 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL simul_store got req=%0b we=%0b be=%h addr=%h wdata=%h exp 1/1/f/10/deadbeef", mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_5555;
    #1;
    checks++; if ({dm_ready, if_ready, if_stall} !== 3'b101) begin errors++; $display("FAIL simul_store_ready got dm/if/if_stall %b exp 101", {dm_ready, if_ready, if_stall}); end
    @(negedge clk);
    mem_ack = 1'b0; dm_req = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL simul_gap got mem_req %0b exp 0", mem_req); end
    @(negedge clk);
    checks++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h400) begin errors++; $display("FAIL simul_fetch got req=%0b we=%0b addr=%h exp 1/0/400", mem_req, mem_we, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    #1;
    checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h0BAD_CAFE) begin errors++; $display("FAIL simul_fetch_ready got %0b/%h exp 1/0badcafe", if_ready, if_rdata); end
    @(negedge clk);
    mem_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
    checks++; if (if_pulses - pi !== 1 || dm_pulses - pd !== 1) begin errors++; $display("FAIL simul_pulses got if=%0d dm=%0d exp 1/1", if_pulses - pi, dm_pulses - pd); end
  endtask

  task automatic test_starvation();
    logic [9:0] seq;
    int pi, pd;
    bit lost;
    seq = '0; lost = 1'b0;
    pi = if_pulses; pd = dm_pulses;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0800;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'h3; dm_addr = 32'h0000_0020;
    for (int g = 0; g < 10; g++) begin
      for (int w = 0; w < 4; w++) begin
        @(negedge clk);
        if (mem_req) break;
      end
      if (!mem_req) begin lost = 1'b1; break; end
      seq[g] = (mem_addr == 32'h0000_0800);
      mem_ack = 1'b1; mem_rdata = 32'(g);
      #1;
      @(negedge clk);
      mem_ack = 1'b0;
      if (g == 9) begin if_req = 1'b0; dm_req = 1'b0; end
    end
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    checks++; if (lost) begin errors++; $display("FAIL starve_grant_timeout got no grant exp grant within 4 cycles"); end
    checks++; if (seq !== 10'b10_0001_0000) begin errors++; $display("FAIL starve_order got %b exp 1000010000 (bit0 = first grant, 1 = fetch)", seq); end
    @(negedge clk);
    checks++; if (if_pulses - pi !== 2 || dm_pulses - pd !== 8) begin errors++; $display("FAIL starve_pulses got if=%0d dm=%0d exp 2/8", if_pulses - pi, dm_pulses - pd); end
  endtask

  task automatic test_timeout();
    int cyc;
    logic [31:0] rd;
    cyc = 0; rd = 32'hX;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h0000_0044; mem_rdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk); #1;
      if (dm_ready) begin cyc = c; rd = dm_rdata; break; end
    end
    checks++; if (cyc !== 256) begin errors++; $display("FAIL timeout_cycle got %0d exp 256", cyc); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL timeout_rdata got %h exp 00000000", rd); end
    @(negedge clk);
    dm_req = 1'b0;
    checks++; if ({bus_err, mem_req} !== 2'b10) begin errors++; $display("FAIL timeout_err got bus_err=%0b mem_req=%0b exp 1/0", bus_err, mem_req); end
    if_req = 1'b1; if_addr = 32'h0000_0100;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    checks++; if (if_ready !== 1'b1 || if_rdata !== 32'h1234_5678) begin errors++; $display("FAIL timeout_fetch got %0b/%h exp 1/12345678", if_ready, if_rdata); end
    @(negedge clk);
    mem_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %0b exp 1", bus_err); end
  endtask

  task automatic test_collision();
    int early;
    early = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL collision_reset_err got %0b exp 0", bus_err); end
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0048; mem_rdata = 32'h7777_7777;
    for (int c = 1; c <= 255; c++) begin
      @(negedge clk); #1;
      if (dm_ready) early++;
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    checks++; if (dm_ready !== 1'b1 || dm_rdata !== 32'hCAFE_F00D || early !== 0) begin
      errors++; $display("FAIL collision_ack got ready=%0b rdata=%h early=%0d exp 1/cafef00d/0", dm_ready, dm_rdata, early);
    end
    @(negedge clk);
    mem_ack = 1'b0; dm_req = 1'b0;
    checks++; if ({bus_err, mem_req} !== 2'b00) begin errors++; $display("FAIL collision_err got bus_err=%0b mem_req=%0b exp 0/0", bus_err, mem_req); end
  endtask

  task automatic test_reset_mid_grant();
    int pd;
    pd = dm_pulses;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'h1; dm_addr = 32'h0000_0060; dm_wdata = 32'h0000_A5A5;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_req, dm_ready} !== 2'b00) begin errors++; $display("FAIL rst_mid_drop got mem_req=%0b dm_ready=%0b exp 0/0", mem_req, dm_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (dm_pulses !== pd) begin errors++; $display("FAIL rst_mid_no_ready got %0d pulses exp 0", dm_pulses - pd); end
    checks++; if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h60 || mem_wdata !== 32'hA5A5) begin
      errors++; $display("FAIL rst_mid_regrant got req=%0b we=%0b addr=%h wdata=%h exp 1/1/60/a5a5", mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    #1;
    checks++; if (dm_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_complete got %0b exp 1", dm_ready); end
    @(negedge clk);
    mem_ack = 1'b0; dm_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ack_idle();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_collision();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
